// File: rtl/conv_result_writer_pkg.sv
// Shared constants, write-entry type and address helper
// for the conv result writer.
package conv_result_writer_pkg;

    localparam int BYTE    = 8;
    localparam int ADDR_W  = 16;
    localparam int SAT_MAX = 127;
    localparam int SAT_MIN = -128;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [BYTE-1:0]   data;
    } wr_t;

    // Linear (channel, row, col) address, wrapping in 16 bits.
    function automatic logic [ADDR_W-1:0] lin_addr(
        input logic [BYTE-1:0] i,
        input logic [BYTE-1:0] j,
        input logic [BYTE-1:0] k,
        input int              dim
    );
        logic [ADDR_W-1:0] d;
        d = ADDR_W'(dim);
        return ADDR_W'(i) * d * d + ADDR_W'(j) * d + ADDR_W'(k);
    endfunction

endpackage

// File: rtl/conv_result_writer_fifo.sv
// Small synchronous FIFO buffering result writes.
// Head entry is presented combinationally on dout.
module sync_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       din,
    input  logic                   pop,
    output logic [WIDTH-1:0]       dout,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp;
    logic [AW-1:0]    rp;
    logic             do_push;
    logic             do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop & ~empty;
    // A full FIFO still accepts a push in the same cycle as a pop.
    assign do_push = push & (~full | do_pop);
    assign dout    = mem[rp];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wp] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                wp <= wp + 1'b1;
            end
            if (do_pop) begin
                rp <= rp + 1'b1;
            end
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/conv_result_writer.sv
// Accumulates conv window taps, rounds/saturates the result and
// streams 8-bit writes to output feature-map memory through a FIFO.
module conv_result_writer
    import conv_result_writer_pkg::*;
#(
    parameter int CONV_DIM_OUT = 32,
    parameter int CONV_OUT_CH  = 32,
    parameter int ACC_W        = 32,
    parameter int OUT_SHIFT    = 8,
    parameter int BIAS_SHIFT   = 0,
    parameter int RELU         = 1,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                en_sum,
    input  logic [2*BYTE-1:0]   prod,
    input  logic                win_last,
    input  logic [BYTE-1:0]     i,
    input  logic [BYTE-1:0]     j,
    input  logic [BYTE-1:0]     k,
    input  logic [2*BYTE-1:0]   bias,
    output logic                stall,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [BYTE-1:0]     mem_wdata,
    input  logic                mem_ready,
    output logic                done,
    output logic [BYTE-1:0]     sat_cnt
);

    localparam int TOTAL = CONV_OUT_CH * CONV_DIM_OUT * CONV_DIM_OUT;
    localparam int WCW   = $clog2(TOTAL + 1);
    localparam int CW    = $clog2(FIFO_DEPTH) + 1;

    localparam logic signed [ACC_W:0] HALF =
        $signed((ACC_W+1)'(1)) <<< (OUT_SHIFT - 1);
    localparam logic signed [ACC_W:0] HI = (ACC_W+1)'(SAT_MAX);
    localparam logic signed [ACC_W:0] LO = (ACC_W+1)'(SAT_MIN);

    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] prod_x;
    logic signed [ACC_W-1:0] bias_x;
    logic signed [ACC_W-1:0] sum;
    logic                    accept;

    logic                    s1_valid;
    logic signed [ACC_W-1:0] s1_sum;
    logic [ADDR_W-1:0]       s1_addr;
    logic signed [ACC_W:0]   ext_sum;
    logic signed [ACC_W:0]   rnd;
    logic                    over_pos;
    logic                    over_neg;
    logic                    sat;
    logic [BYTE-1:0]         r8;
    wr_t                     s1_wr;

    wr_t                     head;
    logic [$bits(wr_t)-1:0]  fifo_dout;
    logic                    fifo_full;
    logic                    fifo_empty;
    logic [CW-1:0]           fifo_cnt;
    logic [CW:0]             inflight;
    logic                    pop;
    logic [WCW-1:0]          wr_cnt;

    assign prod_x = ACC_W'($signed(prod));
    assign bias_x = ACC_W'($signed(bias)) <<< BIAS_SHIFT;
    assign sum    = acc + (en_sum ? prod_x : '0) + bias_x;
    assign accept = (en_sum | win_last) & ~stall & ~done;

    // Round half up, then arithmetic shift down to output scale.
    assign ext_sum  = {s1_sum[ACC_W-1], s1_sum};
    assign rnd      = (ext_sum + HALF) >>> OUT_SHIFT;
    assign over_pos = rnd > HI;
    assign over_neg = rnd < LO;
    assign sat      = over_pos | (over_neg & (RELU == 0));

    always_comb begin
        r8 = rnd[BYTE-1:0];
        if (over_pos) begin
            r8 = 8'h7f;
        end else if (RELU != 0 && rnd < 0) begin
            r8 = '0;
        end else if (over_neg) begin
            r8 = 8'h80;
        end
    end

    assign s1_wr = '{addr: s1_addr, data: r8};

    sync_fifo #(
        .WIDTH ($bits(wr_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (s1_valid),
        .din   (s1_wr),
        .pop   (pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_cnt)
    );

    assign head      = fifo_dout;
    assign mem_we    = ~fifo_empty;
    assign mem_addr  = fifo_empty ? '0 : head.addr;
    assign mem_wdata = fifo_empty ? '0 : head.data;
    assign pop       = mem_we & mem_ready;

    // Reserve one slot for the entry that may be in stage 1.
    assign inflight = {1'b0, fifo_cnt} + (CW+1)'(s1_valid);
    assign stall    = inflight >= (CW+1)'(FIFO_DEPTH - 1);

    always_ff @(posedge clk) begin
        if (reset) begin
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_sum   <= '0;
            s1_addr  <= '0;
        end else begin
            s1_valid <= accept & win_last;
            if (accept && win_last) begin
                s1_sum  <= sum;
                s1_addr <= lin_addr(i, j, k, CONV_DIM_OUT);
                acc     <= '0;
            end else if (accept) begin
                acc <= acc + prod_x;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sat_cnt <= '0;
            wr_cnt  <= '0;
            done    <= 1'b0;
        end else begin
            if (s1_valid && sat && sat_cnt != 8'hff) begin
                sat_cnt <= sat_cnt + 1'b1;
            end
            if (pop) begin
                wr_cnt <= wr_cnt + 1'b1;
                if (wr_cnt == WCW'(TOTAL - 1)) begin
                    done <= 1'b1;
                end
            end
        end
    end

    a_no_lost_push: assert property (
        @(posedge clk) disable iff (reset)
        !(s1_valid && fifo_full && !pop)
    );

endmodule

// File: tb/tb_conv_result_writer.sv
// Self-checking bench: two configurations driven in parallel and
// checked each cycle against a queue-based window/write model.
module tb_conv_result_writer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        en_sum = 1'b0;
    logic        win_last = 1'b0;
    logic        mem_ready = 1'b1;
    logic [15:0] prod = '0;
    logic [15:0] bias = '0;
    logic [7:0]  i = '0;
    logic [7:0]  j = '0;
    logic [7:0]  k = '0;

    logic        stall_a, we_a, done_a;
    logic [15:0] addr_a;
    logic [7:0]  wd_a, sat_a;
    logic        stall_b, we_b, done_b;
    logic [15:0] addr_b;
    logic [7:0]  wd_b, sat_b;

    always #5 clk = ~clk;

    conv_result_writer #(
        .CONV_DIM_OUT(4), .CONV_OUT_CH(2), .ACC_W(32),
        .OUT_SHIFT(8), .BIAS_SHIFT(0), .RELU(1), .FIFO_DEPTH(4)
    ) dut_a (
        .clk(clk), .reset(reset), .en_sum(en_sum), .prod(prod),
        .win_last(win_last), .i(i), .j(j), .k(k), .bias(bias),
        .stall(stall_a), .mem_we(we_a), .mem_addr(addr_a),
        .mem_wdata(wd_a), .mem_ready(mem_ready), .done(done_a),
        .sat_cnt(sat_a)
    );

    conv_result_writer #(
        .CONV_DIM_OUT(4), .CONV_OUT_CH(2), .ACC_W(32),
        .OUT_SHIFT(8), .BIAS_SHIFT(8), .RELU(0), .FIFO_DEPTH(4)
    ) dut_b (
        .clk(clk), .reset(reset), .en_sum(en_sum), .prod(prod),
        .win_last(win_last), .i(i), .j(j), .k(k), .bias(bias),
        .stall(stall_b), .mem_we(we_b), .mem_addr(addr_b),
        .mem_wdata(wd_b), .mem_ready(mem_ready), .done(done_b),
        .sat_cnt(sat_b)
    );

    typedef struct {
        int         addr;
        logic [7:0] da;
        logic [7:0] db;
        bit         sa;
        bit         sb;
        int         avail;
    } ent_t;

    ent_t       q[$];
    longint     acc_m;
    int         cyc = 0;
    int         wr_m, sat_ma, sat_mb;
    bit         done_m;
    int         errors = 0;
    int         checks = 0;
    logic [7:0] last_a, last_b;
    int         pops_a = 0;
    bit         sweep = 0;
    int         sweep_idx = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at t=%0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic void calc(input longint s, input bit relu,
                                 output logic [7:0] r, output bit sat);
        longint t;
        t = (s + 128) >>> 8;
        sat = 0;
        if (t > 127) begin
            t = 127;
            sat = 1;
        end else if (t < -128) begin
            t = -128;
            sat = !relu;
        end
        if (relu && t < 0) t = 0;
        r = t[7:0];
    endfunction

    // Model: in-flight windows, 2-cycle visibility, pop on ready.
    always @(posedge clk) begin : model
        bit     stall_m;
        longint p, b, sa, sb;
        ent_t   e;
        cyc++;
        if (reset) begin
            q.delete();
            acc_m = 0;
            wr_m = 0;
            done_m = 0;
            sat_ma = 0;
            sat_mb = 0;
        end else begin
            stall_m = q.size() >= 3;
            foreach (q[n]) begin
                if (q[n].avail == cyc) begin
                    if (q[n].sa && sat_ma < 255) sat_ma++;
                    if (q[n].sb && sat_mb < 255) sat_mb++;
                end
            end
            if (q.size() > 0 && q[0].avail <= cyc - 1 && mem_ready) begin
                void'(q.pop_front());
                wr_m++;
                if (wr_m == 32) done_m = 1;
            end
            if ((en_sum || win_last) && !stall_m && !done_m) begin
                p = en_sum ? longint'($signed(prod)) : 0;
                if (win_last) begin
                    b = longint'($signed(bias));
                    sa = acc_m + p + b;
                    sb = acc_m + p + b * 256;
                    calc(sa, 1, e.da, e.sa);
                    calc(sb, 0, e.db, e.sb);
                    e.addr = i * 16 + j * 4 + k;
                    e.avail = cyc + 1;
                    q.push_back(e);
                    acc_m = 0;
                end else begin
                    acc_m += p;
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        bit ew;
        ew = q.size() > 0 && q[0].avail <= cyc;
        chk("stall_a", stall_a, q.size() >= 3);
        chk("stall_b", stall_b, q.size() >= 3);
        chk("we_a", we_a, ew);
        chk("we_b", we_b, ew);
        chk("done_a", done_a, done_m);
        chk("done_b", done_b, done_m);
        chk("sat_a", sat_a, sat_ma);
        chk("sat_b", sat_b, sat_mb);
        if (ew) begin
            chk("addr_a", addr_a, q[0].addr);
            chk("addr_b", addr_b, q[0].addr);
            chk("wdata_a", wd_a, q[0].da);
            chk("wdata_b", wd_b, q[0].db);
        end
        if (we_a && mem_ready) begin
            last_a = wd_a;
            last_b = wd_b;
            pops_a++;
            if (sweep) begin
                chk("sweep_addr", addr_a, sweep_idx);
                sweep_idx++;
            end
        end
    end

    task automatic step(input bit e, input int p, input bit w,
                        input int ii, input int jj, input int kk,
                        input int b);
        @(posedge clk);
        #1;
        en_sum = e;
        prod = 16'(p);
        win_last = w;
        i = 8'(ii);
        j = 8'(jj);
        k = 8'(kk);
        bias = 16'(b);
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic win(input int n, input int p, input int ii,
                       input int jj, input int kk, input int b);
        for (int t = 0; t < n - 1; t++) step(1, p, 0, 0, 0, 0, 0);
        step(1, p, 1, ii, jj, kk, b);
    endtask

    task automatic drain();
        int t;
        t = 0;
        idle(1);
        while (q.size() > 0 && t < 60) begin
            idle(1);
            t++;
        end
        if (q.size() > 0) chk("drain_timeout", q.size(), 0);
        idle(1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_stall"}, stall_a, 0);
        chk({tag, "_we"}, we_a, 0);
        chk({tag, "_addr"}, addr_a, 0);
        chk({tag, "_wdata"}, wd_a, 0);
        chk({tag, "_done"}, done_a, 0);
        chk({tag, "_sat"}, sat_a, 0);
        chk({tag, "_sat_b"}, sat_b, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin : stim
        int p0;
        idle(3);
        @(negedge clk);
        chk_reset_vals("rst0");
        @(posedge clk);
        #1 reset = 1'b0;

        // 25 taps of 256 -> 25, visible two cycles after win_last
        win(25, 256, 0, 0, 0, 0);
        idle(1);
        @(negedge clk);
        chk("lat_we_early", we_a, 0);
        idle(1);
        @(negedge clk);
        chk("lat_we", we_a, 1);
        chk("lat_addr", addr_a, 0);
        chk("lat_wdata", wd_a, 25);
        drain();
        chk("t1_b", last_b, 25);

        win(25, 32767, 0, 0, 1, 0);
        drain();
        chk("t2_pos_a", last_a, 8'h7f);
        chk("t2_sat_a", sat_a, 1);
        chk("t2_sat_b", sat_b, 1);
        win(3, -32768, 0, 0, 2, 0);
        drain();
        chk("t2_neg_a", last_a, 0);
        chk("t2_neg_b", last_b, 8'h80);
        chk("t2_relu_sat_a", sat_a, 1);
        chk("t2_neg_sat_b", sat_b, 2);

        win(1, 384, 0, 0, 3, 0);
        drain();
        chk("t3_rnd_a", last_a, 2);
        chk("t3_rnd_b", last_b, 2);
        win(1, -384, 0, 1, 0, 0);
        drain();
        chk("t3_neg_a", last_a, 0);
        chk("t3_neg_b", last_b, 8'hff);
        win(1, 384, 0, 1, 1, 3);
        drain();
        chk("t3_bias_a", last_a, 2);
        chk("t3_bias_b", last_b, 5);

        step(1, 512, 0, 0, 0, 0, 0);
        step(0, 9999, 1, 0, 1, 2, 0);
        drain();
        chk("t5_noprod", last_a, 2);
        win(1, 256, 0, 1, 3, 0);
        drain();
        chk("t5_acc_clear", last_b, 1);

        // back-pressure: windows every cycle into a blocked memory
        @(posedge clk);
        #1 mem_ready = 1'b0;
        for (int n = 0; n < 8; n++) win(1, 256 * (n + 1), 1, n / 4, n % 4, 0);
        idle(2);
        @(negedge clk);
        chk("t4_stall", stall_a, 1);
        p0 = pops_a;
        @(posedge clk);
        #1 mem_ready = 1'b1;
        drain();
        chk("t4_writes", pops_a - p0, 3);

        @(posedge clk);
        #1 reset = 1'b1;
        idle(2);
        @(negedge clk);
        chk_reset_vals("rst1");
        @(posedge clk);
        #1 reset = 1'b0;

        sweep = 1;
        sweep_idx = 0;
        for (int n = 0; n < 32; n++)
            win(1, 256 * (n % 5), n / 16, (n / 4) % 4, n % 4, 0);
        drain();
        sweep = 0;
        chk("t6_count", sweep_idx, 32);
        chk("t6_done", done_a, 1);
        win(1, 256, 0, 0, 0, 0);
        idle(3);
        @(negedge clk);
        chk("t6_after_done_we", we_a, 0);
        chk("t6_after_done", done_a, 1);

        // reset while windows are still buffered
        @(posedge clk);
        #1 reset = 1'b1;
        idle(1);
        @(posedge clk);
        #1 reset = 1'b0;
        mem_ready = 1'b0;
        win(1, 32767, 0, 0, 0, 0);
        win(1, 256, 0, 0, 1, 0);
        idle(3);
        @(negedge clk);
        chk("t6_pre_we", we_a, 1);
        chk("t6_pre_sat", sat_a, 1);
        @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk_reset_vals("rst2");
        p0 = pops_a;
        #1 reset = 1'b0;
        mem_ready = 1'b1;
        idle(5);
        @(negedge clk);
        chk("t6_no_partial", pops_a - p0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
